// File: rtl/histogram_builder_if.sv
// Pixel stream between the image RAM reader (master) and the histogram builder (slave).
interface histogram_builder_if #(
  parameter int PIX_W = 8
);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;
  logic             pix_ready;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/histogram_builder.sv
// Streaming histogram writer: one pixel per cycle bumps its bin, and the finished
// histogram is handed to the prefix-sum accumulator with a one-cycle hist_we.
//
// state | meaning
// IDLE  | waiting for start; hist holds the previous frame
// COUNT | accepting pixels, one bin incremented per accepted pixel
// DONE  | single hand-off cycle, hist_we high while hist is final
module histogram_builder #(
  parameter int PIX_W = 8,
  parameter int BIN_W = 16,
  parameter int CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  histogram_builder_if.slave   pix,
  output logic [BIN_W-1:0]     hist [(2**PIX_W)-1:0],
  output logic                 hist_we,
  output logic                 busy,
  output logic [CNT_W-1:0]     pix_count,
  output logic                 sat
);

  localparam int NBINS = 2**PIX_W;
  localparam logic [BIN_W-1:0] BIN_MAX = {BIN_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t state_q, state_d;
  logic   accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COUNT;
      COUNT:   if (pix.pix_valid && pix.pix_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register, no input-to-output paths.
  assign pix.pix_ready = (state_q == COUNT);
  assign hist_we       = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign accept        = (state_q == COUNT) && pix.pix_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBINS; i++) hist[i] <= '0;
      pix_count <= '0;
      sat       <= 1'b0;
    end else if (state_q == IDLE && start) begin
      for (int i = 0; i < NBINS; i++) hist[i] <= '0;
      pix_count <= '0;
      sat       <= 1'b0;
    end else if (accept) begin
      // Saturate rather than wrap so a hot bin never reads as nearly empty.
      if (hist[pix.pix_data] == BIN_MAX) sat <= 1'b1;
      else hist[pix.pix_data] <= hist[pix.pix_data] + BIN_W'(1);
      if (pix_count != CNT_MAX) pix_count <= pix_count + CNT_W'(1);
    end
  end

endmodule
